anim_sprite: RTL and testbench
==============================

Name: anim_sprite

Overview:
- Parametrised, multi-frame, palette-indexed sprite renderer on the pixel clock, placed between the video timing generator and the pixel mux.
- Stores N_FRAMES frames of WIDTH x HEIGHT indices in one index ROM and maps them through one shared palette ROM.
- A frame sequencer steps through the frames at a programmable rate in one of four playback modes.
- Adds a transparency key and a latency-matched `in_sprite` flag, so upstream logic can overlay the sprite without its own delay matching.

Parameters:
- WIDTH, 256, sprite width in pixels.
- HEIGHT, 256, sprite height in pixels.
- N_FRAMES, 4, number of animation frames (>=1).
- INDEX_W, 8, palette index width; the palette depth is 2^INDEX_W.
- COLOR_W, 12, output pixel width.
- HOLD_W, 6, width of the frames-per-step hold count.
- TRANSPARENT_IDX, 0, palette index treated as transparent.
- IMAGE_FILE, "image.mem", index ROM init file, frames stored back to back.
- PALETTE_FILE, "palette.mem", palette ROM init file.

Ports:
- pixel_clk_in  input  1  pixel clock.
- rst_in  input  1  asynchronous active-low reset.
- hcount_in  input  11  current pixel column.
- vcount_in  input  10  current pixel row.
- x_in  input  11  sprite left edge.
- y_in  input  10  sprite top edge.
- mode_in  input  2  playback mode: 0 STOP, 1 LOOP, 2 PINGPONG, 3 ONESHOT.
- hold_in  input  HOLD_W  video frames per animation step; 0 is treated as 1.
- start_in  input  1  one-cycle pulse that (re)starts playback at frame 0.
- pixel_out  output  COLOR_W  pixel colour; 0 outside the sprite or when transparent.
- opaque_out  output  1  high when pixel_out is a visible sprite pixel.
- frame_out  output  $clog2(N_FRAMES) (min 1)  frame index currently displayed.
- done_out  output  1  high when ONESHOT has finished; cleared by start_in.

Behaviour:
- Reset (rst_in low, asynchronous):
  - pixel_out=0, opaque_out=0, frame_out=0, done_out=0.
  - FSM goes to IDLE, hold counter=0, direction=up, all pipeline valid bits=0.
- Frame boundary (FB): one-cycle event when hcount_in==0 and vcount_in==0. FB sets when the other registers update:
  - x_in and y_in are latched into x_q and y_q at FB only, which prevents tearing mid-frame.
  - mode_in and hold_in are latched at FB only.
  - frame_out changes only at FB.
- Hit test, in stage 0:
  - Comparisons use 12 bits, so x_q+WIDTH and y_q+HEIGHT never wrap.
  - in_sprite = hcount in [x_q, x_q+WIDTH) and vcount in [y_q, y_q+HEIGHT).
- Address: frame_out*WIDTH*HEIGHT + (vcount-y_q)*WIDTH + (hcount-x_q), width $clog2(N_FRAMES*WIDTH*HEIGHT).
  - The address is registered in stage 0. It is don't-care when in_sprite=0.
- Pipeline, fixed latency 5 cycles from hcount_in/vcount_in to pixel_out:
  - 1 cycle for the address register.
  - 2 cycles for the index ROM (registered output).
  - 2 cycles for the palette ROM.
  - The in_sprite flag and the transparency flag (index==TRANSPARENT_IDX, taken at the index ROM output) are delayed to match.
  - pixel_out = (in_sprite and not transparent) ? palette data : 0. opaque_out is the same condition.
- Sequencer FSM; it evaluates only at FB unless noted:
  - IDLE: frame 0, no stepping. start_in -> PLAY in the same cycle (frame 0, hold counter 0, done_out 0).
  - PLAY: hold counter increments at each FB. When it reaches max(hold_in,1)-1 it clears and the frame steps:
    - LOOP: frame+1, wrapping N_FRAMES-1 -> 0.
    - PINGPONG: reverses direction at 0 and at N_FRAMES-1 with no repeated endpoint: 0,1,2,3,2,1,0,1…
    - ONESHOT: at N_FRAMES-1, go to DONE instead of stepping.
    - STOP: hold frame, counter frozen.
  - DONE: frame held at N_FRAMES-1, done_out=1. start_in -> PLAY.
- Mode change while in PLAY takes effect at the next FB. The current frame is kept and the direction resets to up.
- N_FRAMES==1: frame_out is always 0. ONESHOT reaches DONE on its first step.
- start_in coinciding with FB: start_in wins, giving frame 0 and counter 0.
- Reset asserted mid-line: outputs are 0 immediately. After release, the first valid pixel appears 5 cycles after the first sampled counts.

Optional Feature:
- Macro name: ANIM_SPRITE_HFLIP_EN.
- When defined:
  - Adds input port hflip_in (1 bit), latched at FB.
  - When the latched value is 1, the column term becomes WIDTH-1-(hcount-x_q), mirroring the sprite horizontally.
  - Latency is unchanged.
- When undefined: the port is absent and the column term is always hcount-x_q.

Test Plan:
- Reset, then x_in=100, y_in=50, FB, sweep a line at vcount=50 -> pixel_out=0 for hcount<100. Image pixel (0,0) colour appears exactly 5 cycles after hcount_in=100. pixel_out=0 again 5 cycles after hcount_in=100+WIDTH.
- Pixel whose index==TRANSPARENT_IDX inside the sprite -> pixel_out=0 and opaque_out=0 at latency 5. Neighbouring opaque pixel -> opaque_out=1.
- mode_in=1, hold_in=2, N_FRAMES=4, start_in -> frame_out sequence over FBs is 0,0,1,1,2,2,3,3,0. mode_in=2 -> 0,1,2,3,2,1,0 with hold_in=1.
- mode_in=3, hold_in=1 -> frame_out 0,1,2,3, then done_out=1 with frame held at 3. start_in -> done_out=0, frame_out=0.
- Change x_in from 100 to 300 mid-frame -> rendering stays at 100 until the next FB, then moves to 300. x_in=1200 (right edge) -> no wraparound hits at small hcount.
- Assert rst_in low mid-sprite -> pixel_out, opaque_out, frame_out and done_out go to 0 without waiting for a clock edge. With ANIM_SPRITE_HFLIP_EN and hflip_in=1, the pixel at hcount=x gets the colour of column WIDTH-1.

Source files
------------

// File: rtl/anim_sprite.sv
// Multi-frame palette-indexed sprite renderer with frame sequencer, 5-cycle pixel pipeline.
// Optional horizontal mirroring is enabled by defining ANIM_SPRITE_HFLIP_EN.
module anim_sprite #(
    parameter int unsigned WIDTH           = 256,
    parameter int unsigned HEIGHT          = 256,
    parameter int unsigned N_FRAMES        = 4,
    parameter int unsigned INDEX_W         = 8,
    parameter int unsigned COLOR_W         = 12,
    parameter int unsigned HOLD_W          = 6,
    parameter int unsigned TRANSPARENT_IDX = 0,
    parameter              IMAGE_FILE      = "image.mem",
    parameter              PALETTE_FILE    = "palette.mem",
    localparam int unsigned FRAME_W        = (N_FRAMES > 1) ? $clog2(N_FRAMES) : 1
) (
    input  logic               pixel_clk_in,
    input  logic               rst_in,
    input  logic [10:0]        hcount_in,
    input  logic [9:0]         vcount_in,
    input  logic [10:0]        x_in,
    input  logic [9:0]         y_in,
    input  logic [1:0]         mode_in,
    input  logic [HOLD_W-1:0]  hold_in,
    input  logic               start_in,
`ifdef ANIM_SPRITE_HFLIP_EN
    input  logic               hflip_in,
`endif
    output logic [COLOR_W-1:0] pixel_out,
    output logic               opaque_out,
    output logic [FRAME_W-1:0] frame_out,
    output logic               done_out
);

    localparam int unsigned DEPTH     = N_FRAMES * WIDTH * HEIGHT;
    localparam int unsigned ADDR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned PAL_DEPTH = 2 ** INDEX_W;

    typedef enum logic [1:0] {M_STOP, M_LOOP, M_PINGPONG, M_ONESHOT} mode_t;
    typedef enum logic [1:0] {S_IDLE, S_PLAY, S_DONE} state_t;

    // ROM images (IMAGE_FILE / PALETTE_FILE) are supplied by the build flow; no write port.
    logic [INDEX_W-1:0] index_rom   [DEPTH];
    logic [COLOR_W-1:0] palette_rom [PAL_DEPTH];

    logic              fb;
    logic [10:0]       x_q;
    logic [9:0]        y_q;
    logic [1:0]        mode_q;
`ifdef ANIM_SPRITE_HFLIP_EN
    logic              hflip_q;
`endif

    logic [11:0]       h12, v12, x12, y12, col, row;
    logic              in_sprite;
    logic [ADDR_W-1:0] addr_calc, addr_q;
    logic [INDEX_W-1:0] idx_r1, idx_r2;
    logic [COLOR_W-1:0] pal_r1;
    logic              hit_q, hit_r1, hit_r2, vis_r3;

    state_t            state;
    logic [HOLD_W-1:0] hold_cnt, hold_eff;
    logic              hold_hit, dir_down, dir_eff, step_dir, last;
    logic [FRAME_W-1:0] step_frame;

    assign fb = (hcount_in == '0) && (vcount_in == '0);

    always_ff @(posedge pixel_clk_in or negedge rst_in) begin
        if (!rst_in) begin
            x_q     <= '0;
            y_q     <= '0;
            mode_q  <= '0;
`ifdef ANIM_SPRITE_HFLIP_EN
            hflip_q <= 1'b0;
`endif
        end else if (fb) begin
            x_q     <= x_in;
            y_q     <= y_in;
            mode_q  <= mode_in;
`ifdef ANIM_SPRITE_HFLIP_EN
            hflip_q <= hflip_in;
`endif
        end
    end

    // 12-bit hit test so x_q+WIDTH / y_q+HEIGHT cannot wrap
    always_comb begin
        h12 = {1'b0, hcount_in};
        v12 = {2'b0, vcount_in};
        x12 = {1'b0, x_q};
        y12 = {2'b0, y_q};
        in_sprite = (h12 >= x12) && (h12 < x12 + 12'(WIDTH)) &&
                    (v12 >= y12) && (v12 < y12 + 12'(HEIGHT));
        row = v12 - y12;
`ifdef ANIM_SPRITE_HFLIP_EN
        col = hflip_q ? (12'(WIDTH - 1) - (h12 - x12)) : (h12 - x12);
`else
        col = h12 - x12;
`endif
        addr_calc = ADDR_W'(32'(frame_out) * (WIDTH * HEIGHT) + 32'(row) * WIDTH + 32'(col));
    end

    always_ff @(posedge pixel_clk_in) begin
        addr_q <= addr_calc;
        idx_r1 <= index_rom[addr_q];
        idx_r2 <= idx_r1;
        pal_r1 <= palette_rom[idx_r2];
    end

    always_ff @(posedge pixel_clk_in or negedge rst_in) begin
        if (!rst_in) begin
            hit_q      <= 1'b0;
            hit_r1     <= 1'b0;
            hit_r2     <= 1'b0;
            vis_r3     <= 1'b0;
            opaque_out <= 1'b0;
            pixel_out  <= '0;
        end else begin
            hit_q      <= in_sprite;
            hit_r1     <= hit_q;
            hit_r2     <= hit_r1;
            vis_r3     <= hit_r2 && (idx_r2 != INDEX_W'(TRANSPARENT_IDX));
            opaque_out <= vis_r3;
            pixel_out  <= vis_r3 ? pal_r1 : '0;
        end
    end

    // A mode change re-arms the direction to up; stepping then follows the new mode
    always_comb begin
        hold_eff   = (hold_in == '0) ? HOLD_W'(1) : hold_in;
        hold_hit   = hold_cnt >= hold_eff - HOLD_W'(1);
        dir_eff    = (mode_in == mode_q) && dir_down;
        last       = frame_out == FRAME_W'(N_FRAMES - 1);
        step_frame = frame_out;
        step_dir   = dir_eff;
        case (mode_t'(mode_in))
            M_LOOP:    step_frame = last ? '0 : frame_out + FRAME_W'(1);
            M_ONESHOT: step_frame = last ? frame_out : frame_out + FRAME_W'(1);
            M_PINGPONG: begin
                if (N_FRAMES > 1) begin
                    if (!dir_eff) begin
                        if (last) begin
                            step_frame = frame_out - FRAME_W'(1);
                            step_dir   = 1'b1;
                        end else begin
                            step_frame = frame_out + FRAME_W'(1);
                        end
                    end else if (frame_out == '0) begin
                        step_frame = frame_out + FRAME_W'(1);
                        step_dir   = 1'b0;
                    end else begin
                        step_frame = frame_out - FRAME_W'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge pixel_clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state     <= S_IDLE;
            frame_out <= '0;
            hold_cnt  <= '0;
            dir_down  <= 1'b0;
            done_out  <= 1'b0;
        end else if (start_in) begin
            state     <= S_PLAY;
            frame_out <= '0;
            hold_cnt  <= '0;
            dir_down  <= 1'b0;
            done_out  <= 1'b0;
        end else if (fb && state == S_PLAY) begin
            dir_down <= dir_eff;
            if (mode_t'(mode_in) != M_STOP) begin
                if (hold_hit) begin
                    hold_cnt <= '0;
                    if (mode_t'(mode_in) == M_ONESHOT && last) begin
                        state    <= S_DONE;
                        done_out <= 1'b1;
                    end else begin
                        frame_out <= step_frame;
                        dir_down  <= step_dir;
                    end
                end else begin
                    hold_cnt <= hold_cnt + HOLD_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_anim_sprite.sv
// Scoreboard bench for anim_sprite: directed stimulus pushes expected responses with due cycles,
// a monitor pops and compares them against pixel/opaque or frame/done outputs.
module tb_anim_sprite;

    localparam int W  = 16;
    localparam int H  = 8;
    localparam int NF = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [10:0] hcount, x_pos;
    logic [9:0]  vcount, y_pos;
    logic [1:0]  mode;
    logic [5:0]  hold;
    logic        start;
    logic [11:0] pixel;
    logic        opaque;
    logic [1:0]  frame;
    logic        done;
`ifdef ANIM_SPRITE_HFLIP_EN
    logic        hflip;
`endif

    always #5 clk = ~clk;

    anim_sprite #(
        .WIDTH(W), .HEIGHT(H), .N_FRAMES(NF), .INDEX_W(4), .COLOR_W(12),
        .HOLD_W(6), .TRANSPARENT_IDX(0)
    ) dut (
        .pixel_clk_in(clk),
        .rst_in(rst_n),
        .hcount_in(hcount),
        .vcount_in(vcount),
        .x_in(x_pos),
        .y_in(y_pos),
        .mode_in(mode),
        .hold_in(hold),
        .start_in(start),
`ifdef ANIM_SPRITE_HFLIP_EN
        .hflip_in(hflip),
`endif
        .pixel_out(pixel),
        .opaque_out(opaque),
        .frame_out(frame),
        .done_out(done)
    );

    typedef struct {
        int          due;
        int          kind;
        int          tag;
        logic [12:0] want;
    } sb_t;

    sb_t sbq[$];
    int  cyc = 0;
    int  checks = 0;
    int  failures = 0;
    int  step_no = 0;
    int  tx = 0, ty = 0, tf = 0;
    bit  thf = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [3:0] idx_of(input int f, input int r, input int c);
        if (f == 0 && r == 0 && c == 2) return 4'd0;
        return 4'((f * 5 + r * 3 + c) % 15 + 1);
    endfunction

    function automatic logic [11:0] col_of(input int i);
        return 12'(i * 273) ^ 12'h05A;
    endfunction

    function automatic logic [12:0] exp_pix(input int h, input int v);
        int c;
        logic [3:0] idx;
        if (h < tx || h >= tx + W || v < ty || v >= ty + H) return 13'd0;
        c = thf ? (W - 1 - (h - tx)) : (h - tx);
        idx = idx_of(tf, v - ty, c);
        if (idx == 4'd0) return 13'd0;
        return {1'b1, col_of(int'(idx))};
    endfunction

    function automatic string kname(input int kind);
        return (kind == 0) ? "pixel" : "frame";
    endfunction

    task automatic push(input int due, input int kind, input int tag, input logic [12:0] want);
        sb_t e;
        int  pos;
        e.due = due; e.kind = kind; e.tag = tag; e.want = want;
        pos = sbq.size();
        while (pos > 0 && sbq[pos-1].due > due) pos--;
        sbq.insert(pos, e);
    endtask

    task automatic tick(input int h, input int v);
        hcount = 11'(h);
        vcount = 10'(v);
        @(posedge clk);
        #1;
    endtask

    task automatic sweep(input int v, input int h0, input int h1);
        for (int h = h0; h <= h1; h++) begin
            push(cyc + 5, 0, h, exp_pix(h, v));
            tick(h, v);
        end
    endtask

    task automatic fb_step(input int ef, input int ed);
        step_no++;
        push(cyc + 1, 1, step_no, 13'(ed * 4 + ef));
        tick(0, 0);
        tick(1, 0);
    endtask

    task automatic start_pulse(input bit at_fb);
        step_no++;
        start = 1'b1;
        push(cyc + 1, 1, step_no, 13'd0);
        if (at_fb) tick(0, 0);
        else       tick(5, 5);
        start = 1'b0;
        tick(1, 0);
    endtask

    // Monitor: compares every entry that falls due this cycle
    initial begin
        sb_t e;
        logic [12:0] act;
        forever begin
            @(posedge clk);
            #3;
            while (sbq.size() > 0 && sbq[0].due <= cyc) begin
                e = sbq.pop_front();
                act = (e.kind == 0) ? {opaque, pixel} : {10'd0, done, frame};
                checks++;
                if (e.due != cyc) begin
                    failures++;
                    $display("FAIL %s tag=%0d late: due=%0d now=%0d", kname(e.kind), e.tag, e.due, cyc);
                end else if (act !== e.want) begin
                    failures++;
                    $display("FAIL %s tag=%0d cyc=%0d got=%h expected=%h", kname(e.kind), e.tag, cyc, act, e.want);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b1;
        hcount = '0; vcount = '0; x_pos = '0; y_pos = '0;
        mode = '0; hold = '0; start = 1'b0;
`ifdef ANIM_SPRITE_HFLIP_EN
        hflip = 1'b0;
`endif
        for (int a = 0; a < NF * W * H; a++)
            dut.index_rom[a] = idx_of(a / (W * H), (a % (W * H)) / W, a % W);
        for (int i = 0; i < 16; i++)
            dut.palette_rom[i] = col_of(i);
        #1 rst_n = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        push(cyc, 0, -1, 13'd0);
        push(cyc, 1, 0, 13'd0);
        tick(7, 7);
        rst_n = 1'b1;

        // Placement, latency, transparency and right/bottom edges
        x_pos = 11'd100; y_pos = 10'd50;
        tick(0, 0);
        tx = 100; ty = 50;
        sweep(50, 90, 120);
        sweep(53, 98, 102);
        sweep(57, 112, 117);
        sweep(58, 100, 104);

        // Position change mid-frame holds until the next frame boundary
        x_pos = 11'd300;
        sweep(51, 98, 104);
        sweep(51, 298, 302);
        tick(0, 0);
        tx = 300;
        sweep(51, 298, 317);
        x_pos = 11'd1200;
        tick(0, 0);
        tx = 1200;
        sweep(50, 1, 20);
        sweep(50, 1212, 1218);

        // LOOP, hold 2
        mode = 2'd1; hold = 6'd2;
        start_pulse(1'b0);
        fb_step(0, 0); fb_step(1, 0); fb_step(1, 0); fb_step(2, 0);
        fb_step(2, 0); fb_step(3, 0); fb_step(3, 0); fb_step(0, 0);

        // PINGPONG, hold 1
        mode = 2'd2; hold = 6'd1;
        start_pulse(1'b0);
        fb_step(1, 0); fb_step(2, 0); fb_step(3, 0); fb_step(2, 0);
        fb_step(1, 0); fb_step(0, 0); fb_step(1, 0);

        // ONESHOT, restart, start coinciding with a frame boundary
        mode = 2'd3;
        start_pulse(1'b0);
        fb_step(1, 0); fb_step(2, 0); fb_step(3, 0); fb_step(3, 1); fb_step(3, 1);
        start_pulse(1'b0);
        fb_step(1, 0); fb_step(2, 0);
        start_pulse(1'b1);
        fb_step(1, 0);

        // STOP freezes, hold 0 behaves as 1
        mode = 2'd0;
        fb_step(1, 0); fb_step(1, 0);
        mode = 2'd1; hold = 6'd0;
        fb_step(2, 0); fb_step(3, 0);

        // Frame 3 pixels, then asynchronous reset mid-sprite
        mode = 2'd0; x_pos = 11'd100; y_pos = 10'd50;
        fb_step(3, 0);
        tx = 100; ty = 50; tf = 3;
        sweep(52, 96, 108);
        for (int h = 109; h <= 113; h++) tick(h, 52);
        rst_n = 1'b0;
        push(cyc, 0, -2, 13'd0);
        push(cyc, 1, step_no + 1, 13'd0);
        tick(114, 52);
        tick(115, 52);
        rst_n = 1'b1;
        tx = 0; ty = 0; tf = 0;
        for (int k = 0; k < 5; k++) push(cyc + k, 0, -3, 13'd0);
        sweep(2, 0, 20);

`ifdef ANIM_SPRITE_HFLIP_EN
        hflip = 1'b1; x_pos = 11'd100; y_pos = 10'd50;
        tick(0, 0);
        tx = 100; ty = 50; thf = 1'b1;
        sweep(50, 98, 118);
`endif

        tick(3, 3);
        for (int i = 0; i < 20 && sbq.size() > 0; i++) tick(3, 3);
        while (sbq.size() > 0) begin
            sb_t e;
            e = sbq.pop_front();
            checks++;
            failures++;
            $display("FAIL %s tag=%0d never checked: due=%0d now=%0d", kname(e.kind), e.tag, e.due, cyc);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
